// File: rtl/rms_sample_feeder.sv
// rms_sample_feeder: sample FIFO plus issue sequencer in front of the RMS core.
// Samples arrive over valid/ready, are buffered, and are handed to the core one
// at a time as `a` with a one-cycle `start`, waiting for `done` between issues.
// Optional feature macro: RMS_FEED_TIMEOUT_EN (abort an issue when `done` never
// arrives within TIMEOUT cycles; sets sticky `timeout_err`).
//
// Handshake: a sample transfers on a rising edge where in_valid && in_ready;
// in_valid is ignored while in_ready is low, and in_ready is low during rst.
module rms_sample_feeder #(
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          in_data,
   output logic                       in_ready,
   output logic [DATA_W-1:0]          a,
   output logic                       start,
   input  logic                       done,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       busy,
   output logic                       timeout_err,
   output logic                       state_dbg
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   // Elaboration-time parameter sanity checks.
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("rms_sample_feeder: DEPTH must be a power of 2 and at least 2");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("rms_sample_feeder: TIMEOUT must be at least 1");
   end

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]    level_q, level_d;
   logic [DATA_W-1:0]   a_q, a_d;
   logic                start_q, start_d;
   logic                busy_q, busy_d;
   logic                push;
   logic                pop;
   logic                abort;

   // No bypass: a sample must sit in the FIFO for one edge before it can issue.
   assign in_ready = !rst && (level_q != LVL_W'(DEPTH));
   assign push     = in_valid && in_ready;

`ifdef RMS_FEED_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   // The count reaches TIMEOUT on the edge where cnt_q holds TIMEOUT-1; a done
   // on that same edge wins and the issue completes normally.
   assign abort = (state_q == S_WAIT) && !done && (cnt_q == CNT_W'(TIMEOUT - 1));

   // Cycle counter restarted on every issue, plus the sticky error flag.
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (pop) begin
         cnt_d = '0;
      end else if (state_q == S_WAIT) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      if (abort) begin
         err_d = 1'b1;
      end
   end

   // Timeout state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign timeout_err = err_q;
`else
   assign abort       = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // Issue sequencer and FIFO bookkeeping next-state logic.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      start_d  = 1'b0;
      busy_d   = busy_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      level_d  = level_q;
      pop      = 1'b0;

      case (state_q)
         S_IDLE: begin
            // done is deliberately ignored here.
            if (level_q != '0) begin
               pop = 1'b1;
            end
         end
         S_WAIT: begin
            if (done) begin
               if (level_q != '0) begin
                  pop = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
               end
            end else if (abort) begin
               // The in-flight sample is dropped; queued ones issue from IDLE.
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // a only changes on an issue, so it holds steady between starts.
      if (pop) begin
         a_d      = mem_q[rd_ptr_q];
         start_d  = 1'b1;
         busy_d   = 1'b1;
         state_d  = S_WAIT;
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end

      case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   // Control and output registers; reset flushes everything mid-operation too.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         start_q  <= 1'b0;
         busy_q   <= 1'b0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         start_q  <= start_d;
         busy_q   <= busy_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         level_q  <= level_d;
      end
   end

   // FIFO storage; contents need no reset since level gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   assign a         = a_q;
   assign start     = start_q;
   assign busy      = busy_q;
   assign level     = level_q;
   assign state_dbg = (state_q == S_WAIT);

endmodule

// File: tb/tb_rms_sample_feeder.sv
// Testbench for rms_sample_feeder: core model answering start with done,
// cycle monitor with expected-sample queue, and directed scenario tasks.
module tb_rms_sample_feeder;

   localparam int DATA_W  = 8;
   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 64;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_ready;
   logic [DATA_W-1:0] a;
   logic              start;
   logic              done;
   logic [3:0]        level;
   logic              busy;
   logic              timeout_err;
   logic              state_dbg;

   int total = 0;
   int bad   = 0;

   logic [DATA_W-1:0] exp_q[$];

   bit mon_en     = 1'b0;
   int core_lat   = 5;
   bit core_en    = 1'b1;
   int core_cnt   = -1;
   int done_cnt   = 0;
   int sim_events = 0;
   int saw_full   = 0;

   // clock / reset
   always #5 clk = ~clk;

   rms_sample_feeder #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .a           (a),
      .start       (start),
      .done        (done),
      .level       (level),
      .busy        (busy),
      .timeout_err (timeout_err),
      .state_dbg   (state_dbg)
   );

   // Stimulus and directed checks happen 1 time unit after the falling edge.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // RMS core model: done is high in the cycle core_lat cycles after start.
   initial begin
      done = 1'b0;
      forever begin
         @(negedge clk);
         done = 1'b0;
         if (core_cnt == 0) begin
            done     = 1'b1;
            done_cnt = done_cnt + 1;
            core_cnt = -1;
         end else if (core_cnt > 0) begin
            core_cnt = core_cnt - 1;
         end
         if (start === 1'b1 && core_en) begin
            core_cnt = core_lat - 1;
         end
      end
   end

   // Cycle monitor: expected outputs from a behavioural model; scoreboard
   // queue filled on accept and drained when the DUT raises start.
   initial begin
      int          lvl_exp   = 0;
      bit          busy_exp  = 1'b0;
      bit          start_exp = 1'b0;
      logic [7:0]  a_exp     = '0;
      int          tcnt      = 0;
      bit          err_exp   = 1'b0;
      bit          rdy_exp;
      bit          push;
      bit          pop;
      bit          abort;
      logic [7:0]  e;
      forever begin
         @(negedge clk);
         #2;
         rdy_exp = !rst && (lvl_exp != DEPTH);
         if (mon_en) begin
            total = total + 1;
            if (level !== 4'(lvl_exp)) begin
               bad = bad + 1;
               $display("FAIL mon_level: got %0d expected %0d at %0t", level, lvl_exp, $time);
            end
            total = total + 1;
            if (busy !== busy_exp) begin
               bad = bad + 1;
               $display("FAIL mon_busy: got %0b expected %0b at %0t", busy, busy_exp, $time);
            end
            total = total + 1;
            if (in_ready !== rdy_exp) begin
               bad = bad + 1;
               $display("FAIL mon_in_ready: got %0b expected %0b at %0t", in_ready, rdy_exp, $time);
            end
            total = total + 1;
            if (start !== start_exp) begin
               bad = bad + 1;
               $display("FAIL mon_start: got %0b expected %0b at %0t", start, start_exp, $time);
            end
            total = total + 1;
            if (timeout_err !== err_exp) begin
               bad = bad + 1;
               $display("FAIL mon_timeout_err: got %0b expected %0b at %0t", timeout_err, err_exp, $time);
            end
            if (start === 1'b1) begin
               total = total + 1;
               if (exp_q.size() == 0) begin
                  bad = bad + 1;
                  $display("FAIL mon_issue_order: got a=%0d expected no issue at %0t", a, $time);
               end else begin
                  e = exp_q.pop_front();
                  a_exp = e;
                  if (a !== e) begin
                     bad = bad + 1;
                     $display("FAIL mon_issue_order: got a=%0d expected %0d at %0t", a, e, $time);
                  end
               end
            end else begin
               total = total + 1;
               if (a !== a_exp) begin
                  bad = bad + 1;
                  $display("FAIL mon_a_hold: got %0d expected %0d at %0t", a, a_exp, $time);
               end
            end
         end
         // advance the model across the coming rising edge
         if (rst) begin
            lvl_exp   = 0;
            busy_exp  = 1'b0;
            start_exp = 1'b0;
            a_exp     = '0;
            tcnt      = 0;
            err_exp   = 1'b0;
            exp_q.delete();
         end else begin
            push  = in_valid && rdy_exp;
            pop   = (lvl_exp != 0) && (!busy_exp || done);
            abort = 1'b0;
`ifdef RMS_FEED_TIMEOUT_EN
            abort = busy_exp && !done && (tcnt == TIMEOUT - 1);
`endif
            if (push) exp_q.push_back(in_data);
            if (push && pop) sim_events = sim_events + 1;
            if (pop) tcnt = 0;
            else if (busy_exp) tcnt = tcnt + 1;
            if (abort) err_exp = 1'b1;
            if (pop) busy_exp = 1'b1;
            else if (busy_exp && (done || abort)) busy_exp = 1'b0;
            start_exp = pop;
            lvl_exp   = lvl_exp + int'(push) - int'(pop);
         end
      end
   end

   // driver: hold a sample until accepted (re-presenting while in_ready is low)
   task automatic push_sample(input logic [7:0] v);
      int tries = 0;
      in_valid = 1'b1;
      in_data  = v;
      while (in_ready !== 1'b1 && tries < 500) begin
         total = total + 1;
         if (level !== 4'd8) begin
            bad = bad + 1;
            $display("FAIL ready_low_level: got level %0d expected 8", level);
         end
         saw_full = saw_full + 1;
         tick();
         tries = tries + 1;
      end
      if (tries >= 500) begin
         total = total + 1;
         bad = bad + 1;
         $display("FAIL push_wait: got no in_ready expected in_ready within 500 cycles");
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!(level === 4'd0 && busy === 1'b0 && core_cnt == -1 && done === 1'b0) && n < 2000) begin
         tick();
         n = n + 1;
      end
      total = total + 1;
      if (n >= 2000) begin
         bad = bad + 1;
         $display("FAIL wait_idle: got level=%0d busy=%0b expected drained within 2000 cycles", level, busy);
      end
   endtask

   task automatic test_reset();
      tick();
      mon_en = 1'b1;
      tick();
      total = total + 6;
      if (level !== 4'd0) begin bad++; $display("FAIL reset_level: got %0d expected 0", level); end
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      if (start !== 1'b0) begin bad++; $display("FAIL reset_start: got %0b expected 0", start); end
      if (a !== 8'd0) begin bad++; $display("FAIL reset_a: got %0d expected 0", a); end
      if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b expected 0", timeout_err); end
      if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready); end
      rst = 1'b0;
      tick();
      total = total + 1;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %0b expected 1", in_ready); end
   endtask

   task automatic test_single();
      int n = 0;
      core_lat = 41;
      wait_idle();
      push_sample(8'd42);
      total = total + 2;
      if (level !== 4'd1) begin bad++; $display("FAIL single_level: got %0d expected 1", level); end
      if (start !== 1'b0) begin bad++; $display("FAIL single_early_start: got %0b expected 0", start); end
      tick();
      total = total + 3;
      if (start !== 1'b1) begin bad++; $display("FAIL single_start: got %0b expected 1", start); end
      if (a !== 8'd42) begin bad++; $display("FAIL single_a: got %0d expected 42", a); end
      if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %0b expected 1", busy); end
      while (busy === 1'b1 && n < 200) begin
         tick();
         n = n + 1;
      end
      total = total + 3;
      if (n !== 42) begin bad++; $display("FAIL single_busy_len: got %0d expected 42", n); end
      if (level !== 4'd0) begin bad++; $display("FAIL single_level_end: got %0d expected 0", level); end
      if (state_dbg !== 1'b0) begin bad++; $display("FAIL single_state_idle: got %0b expected 0", state_dbg); end
   endtask

   task automatic test_burst_back_to_back();
      logic [7:0] vals [6];
      int peak = 0;
      vals = '{8'd42, 8'd45, 8'd47, 8'd51, 8'd49, 8'd50};
      core_lat = 10;
      wait_idle();
      foreach (vals[i]) begin
         push_sample(vals[i]);
         if (int'(level) > peak) peak = int'(level);
      end
      total = total + 1;
      if (peak !== 5) begin bad++; $display("FAIL burst_peak: got %0d expected 5", peak); end
      wait_idle();
   endtask

   task automatic test_full();
      core_lat = 30;
      saw_full = 0;
      wait_idle();
      for (int i = 0; i < 10; i++) push_sample(8'(100 + 3 * i));
      total = total + 1;
      if (saw_full == 0) begin bad++; $display("FAIL full_ready_low: got %0d stalled cycles expected >0", saw_full); end
      wait_idle();
      total = total + 1;
      if (level !== 4'd0) begin bad++; $display("FAIL full_drain: got %0d expected 0", level); end
   endtask

   task automatic test_wrap();
      int s0;
      core_lat = 3;
      wait_idle();
      s0 = sim_events;
      for (int i = 0; i < 20; i++) push_sample(8'($urandom_range(0, 255)));
      total = total + 1;
      if (sim_events <= s0) begin bad++; $display("FAIL wrap_simultaneous: got %0d events expected >0", sim_events - s0); end
      wait_idle();
   endtask

   task automatic test_reset_mid();
      int d0;
      int starts = 0;
      core_lat = 50;
      wait_idle();
      for (int i = 0; i < 4; i++) push_sample(8'(200 + i));
      total = total + 2;
      if (level !== 4'd3) begin bad++; $display("FAIL mid_level_before: got %0d expected 3", level); end
      if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %0b expected 1", busy); end
      rst = 1'b1;
      tick();
      total = total + 5;
      if (level !== 4'd0) begin bad++; $display("FAIL mid_level: got %0d expected 0", level); end
      if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %0b expected 0", busy); end
      if (start !== 1'b0) begin bad++; $display("FAIL mid_start: got %0b expected 0", start); end
      if (a !== 8'd0) begin bad++; $display("FAIL mid_a: got %0d expected 0", a); end
      if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_in_ready: got %0b expected 0", in_ready); end
      d0 = done_cnt;
      rst = 1'b0;
      tick();
      total = total + 1;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_after: got %0b expected 1", in_ready); end
      for (int i = 0; i < 70; i++) begin
         if (start === 1'b1) starts = starts + 1;
         tick();
      end
      total = total + 3;
      if (done_cnt <= d0) begin bad++; $display("FAIL mid_stray_done_seen: got %0d expected >%0d", done_cnt, d0); end
      if (starts !== 0) begin bad++; $display("FAIL mid_stray_start: got %0d expected 0", starts); end
      if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy_after: got %0b expected 0", busy); end
      wait_idle();
   endtask

`ifdef RMS_FEED_TIMEOUT_EN
   task automatic test_timeout();
      int n = 0;
      core_en = 1'b0;
      wait_idle();
      push_sample(8'd11);
      push_sample(8'd22);
      total = total + 1;
      if (start !== 1'b1) begin bad++; $display("FAIL to_start: got %0b expected 1", start); end
      while (timeout_err !== 1'b1 && n < 200) begin
         tick();
         n = n + 1;
      end
      total = total + 2;
      if (n !== 64) begin bad++; $display("FAIL to_latency: got %0d expected 64", n); end
      if (busy !== 1'b0) begin bad++; $display("FAIL to_busy: got %0b expected 0", busy); end
      tick();
      total = total + 2;
      if (start !== 1'b1) begin bad++; $display("FAIL to_next_start: got %0b expected 1", start); end
      if (a !== 8'd22) begin bad++; $display("FAIL to_next_a: got %0d expected 22", a); end
      wait_idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      total = total + 1;
      if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_clear: got %0b expected 0", timeout_err); end
      core_en  = 1'b1;
      core_lat = 63;
      push_sample(8'd77);
      tick();
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         tick();
         n = n + 1;
      end
      total = total + 2;
      if (n !== 64) begin bad++; $display("FAIL to_edge_len: got %0d expected 64", n); end
      if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_edge_err: got %0b expected 0", timeout_err); end
      wait_idle();
   endtask
`endif

   // watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got no end expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single();
      test_burst_back_to_back();
      test_full();
      test_wrap();
      test_reset_mid();
`ifdef RMS_FEED_TIMEOUT_EN
      test_timeout();
`endif
      repeat (3) tick();
      if (exp_q.size() != 0) begin
         total = total + 1;
         bad = bad + 1;
         $display("FAIL final_queue: got %0d pending expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rms_sample_feeder.md
# rms_sample_feeder

Upstream sample buffer and sequencer for the RMS core. Accepts 8-bit samples from the acquisition side over a valid/ready handshake and stores them in a small FIFO. Issues them one at a time to the RMS core as `a` plus a one-cycle `start` pulse, then waits for the core's `done` before issuing the next. This removes the need for producers to pace samples to the core's multi-cycle computation time.

## Interface
- `DATA_W`, 8: sample width; matches the RMS core `a` input.
- `DEPTH`, 8: FIFO entries; must be a power of 2, at least 2.
- `TIMEOUT`, 64: cycles to wait for `done` before aborting; used only when the macro is enabled.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  producer has a sample on `in_data`.
- `in_data`  in  DATA_W  sample value.
- `in_ready`  out  1  FIFO can accept a sample.
- `a`  out  DATA_W  sample presented to the RMS core.
- `start`  out  1  one-cycle pulse telling the core to latch `a`.
- `done`  in  1  one-cycle completion pulse from the RMS core.
- `level`  out  $clog2(DEPTH)+1  number of FIFO entries currently held.
- `busy`  out  1  high while a sample is in flight in the core.
- `timeout_err`  out  1  sticky abort flag.

## Operation
- **Push:**
  - A sample is written on a rising edge with `in_valid && in_ready`.
  - `in_ready = !rst && (level != DEPTH)`; there is no full-bypass.
  - `in_valid` is ignored while `in_ready` is low, so no data is lost or overwritten.
- **FSM states:** IDLE, WAIT.
  - **IDLE:** if `level != 0` on an edge, pop the head into `a`, register `start = 1` and go to WAIT. Otherwise stay in IDLE with `start = 0`.
  - **WAIT:** `start` drops to 0 after one cycle and `busy = 1`. On an edge with `done = 1`:
    - if `level != 0`, pop, reload `a`, pulse `start` again and stay in WAIT (back-to-back issue);
    - otherwise go to IDLE with `busy = 0`.
- `done` is ignored in IDLE.
- **`a` stability:** `a` is stable from the `start` cycle until the next `start`. It is not cleared on `done`.
- **Simultaneous push and pop:** `level` is unchanged and the FIFO order is preserved.
- **Pointers:** read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. `level` is a separate counter.
- **Reset (including mid-operation):**
  - Reset flushes the FIFO, returns the FSM to IDLE and clears the timeout counter.
  - A `done` arriving after reset is ignored.
  - Output values while and after `rst` is high: `a = 0`, `start = 0`, `level = 0`, `busy = 0`, `timeout_err = 0`, `in_ready = 0`. `in_ready` rises in the first cycle after `rst` falls.

## Timing
- **Accept to start:** a sample accepted at edge E0 into an empty FIFO with the FSM in IDLE raises `level` to 1 after E0. `start` and `a` are valid for the cycle after edge E1, so the latency is 2 edges.
- **Done to start:** with samples queued, `start` is high in the cycle immediately after the `done` cycle.
- **start width:** `start` is never high for two consecutive cycles, and is never high while a previous sample is unfinished.
- **Registered outputs:** `level` and `busy` are registered and update on the same edge as the push or pop.

## Configuration
- `RMS_FEED_TIMEOUT_EN` defined:
  - In WAIT, a counter starts at 0 on each `start` and counts cycles.
  - If it reaches `TIMEOUT` without `done`, the in-flight sample is discarded, `timeout_err` is set (sticky, cleared only by `rst`) and the FSM goes to IDLE.
  - Queued samples are then issued normally.
  - A `done` in the same cycle the count reaches `TIMEOUT` takes priority: normal completion, no error.
- `RMS_FEED_TIMEOUT_EN` not defined:
  - WAIT holds until `done` indefinitely.
  - `timeout_err` is tied to 0 and no counter is built.

## Test plan
- **Single sample:** release reset, push 42 with the core model giving `done` 41 cycles after `start` -> `a = 42` and `start` high exactly 2 edges after the accept. `busy` stays high until `done`, then `level = 0` and the FSM is in IDLE.
- **Burst:** push 42, 45, 47, 51, 49, 50 on consecutive cycles -> `level` peaks at 5. The samples are issued in that order, each `start` one cycle after the previous `done`, with `a` held between starts.
- **Full FIFO:** push 10 samples back-to-back with `DEPTH = 8` while the core is busy -> `in_ready` goes low when `level = 8`. Samples offered while `in_ready = 0` are not accepted and must be re-presented by the producer. Every accepted sample is issued, and `level` returns to 0 after the last `done`.
- **Wrap and simultaneous events:** sustain 20 pushes, with a push coinciding with a `done`-triggered pop -> `level` unchanged on that edge and the output order matches the input order across pointer wrap.
- **Reset mid-operation:** assert `rst` for 1 cycle while in WAIT with 3 samples queued -> `level = 0`, `busy = 0`, `start = 0`, `a = 0`. A later stray `done` produces no `start`.
- **Timeout (macro on, `TIMEOUT = 64`):** withhold `done` -> `timeout_err = 1` 64 cycles after `start`, and the next queued sample is issued. `done` arriving exactly at count 64 -> `timeout_err` stays 0.
